// File: rtl/lpc_levinson.sv
// Order-10 Levinson-Durbin solver: 16-bit autocorrelation lags in, Q12 predictor
// coefficients and integer residual energy out, one multiply per cycle per phase.
module lpc_levinson (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] R0,
    input  logic signed [15:0] R1,
    input  logic signed [15:0] R2,
    input  logic signed [15:0] R3,
    input  logic signed [15:0] R4,
    input  logic signed [15:0] R5,
    input  logic signed [15:0] R6,
    input  logic signed [15:0] R7,
    input  logic signed [15:0] R8,
    input  logic signed [15:0] R9,
    input  logic signed [15:0] R10,
    input  logic               vin,
    output logic signed [15:0] a1,
    output logic signed [15:0] a2,
    output logic signed [15:0] a3,
    output logic signed [15:0] a4,
    output logic signed [15:0] a5,
    output logic signed [15:0] a6,
    output logic signed [15:0] a7,
    output logic signed [15:0] a8,
    output logic signed [15:0] a9,
    output logic signed [15:0] a10,
    output logic signed [31:0] E,
    output logic               busy,
    output logic               err,
    output logic               vout
);
    typedef enum logic [2:0] {IDLE, LOAD, DOT, DIV, UPD, ENERG, DONE} state_t;

    state_t             state_q;
    logic signed [15:0] r_q  [0:10];
    logic signed [15:0] a_q  [1:10];
    logic signed [15:0] b_q  [1:9];
    logic signed [15:0] ao_q [1:10];
    logic signed [31:0] e_q, eo_q, t_q;
    logic signed [39:0] acc_q;
    logic signed [15:0] k_q;
    logic        [47:0] rem_q, dsr_q;
    logic        [14:0] quo_q;
    logic               neg_q;
    logic        [3:0]  ord_q;
    logic        [4:0]  cnt_q;
    logic               err_q, erro_q, busy_q, vout_q;

    logic        [3:0]  j_idx, m_idx;
    logic signed [31:0] dot_prod, upd_prod, kk_prod, b_d;
    logic signed [63:0] e_prod, e_d;
    logic signed [39:0] acc_sh, acc_abs, e_ext;
    logic        [39:0] acc_mag;
    logic signed [15:0] quo_s;
    logic               div_abort;

    function automatic logic signed [15:0] sat16(input logic signed [31:0] x);
        if (x > 32'sd32767)  return 16'sd32767;
        if (x < -32'sd32768) return 16'sh8000;
        return x[15:0];
    endfunction

    // cnt_q doubles as the coefficient index j in both DOT and UPD
    always_comb begin
        j_idx     = cnt_q[3:0];
        m_idx     = ord_q - j_idx;
        dot_prod  = 32'(a_q[j_idx]) * 32'(r_q[m_idx]);
        upd_prod  = 32'(k_q) * 32'(a_q[m_idx]);
        kk_prod   = 32'(k_q) * 32'(k_q);
        b_d       = 32'(a_q[j_idx]) - (upd_prod >>> 15);
        e_prod    = 64'(t_q) * 64'(e_q);
        e_d       = 64'(e_q) - (e_prod >>> 15);
        acc_sh    = acc_q >>> 12;
        acc_abs   = acc_sh[39] ? -acc_sh : acc_sh;
        e_ext     = 40'(e_q);
        div_abort = (acc_abs >= e_ext);
        acc_mag   = acc_q[39] ? -acc_q : acc_q;
        quo_s     = {1'b0, quo_q};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            for (int j = 0; j <= 10; j++) r_q[j] <= '0;
            for (int j = 1; j <= 10; j++) begin
                a_q[j]  <= '0;
                ao_q[j] <= '0;
            end
            for (int j = 1; j <= 9; j++) b_q[j] <= '0;
            e_q    <= '0;
            eo_q   <= '0;
            t_q    <= '0;
            acc_q  <= '0;
            k_q    <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
            quo_q  <= '0;
            neg_q  <= 1'b0;
            ord_q  <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            erro_q <= 1'b0;
            busy_q <= 1'b0;
            vout_q <= 1'b0;
        end else begin
            vout_q <= 1'b0;
            case (state_q)
                IDLE: if (vin) begin
                    r_q[0] <= R0;  r_q[1] <= R1;  r_q[2] <= R2;  r_q[3] <= R3;
                    r_q[4] <= R4;  r_q[5] <= R5;  r_q[6] <= R6;  r_q[7] <= R7;
                    r_q[8] <= R8;  r_q[9] <= R9;  r_q[10] <= R10;
                    busy_q  <= 1'b1;
                    err_q   <= 1'b0;
                    state_q <= LOAD;
                end
                LOAD: begin
                    for (int j = 1; j <= 10; j++) a_q[j] <= '0;
                    e_q   <= 32'(r_q[0]);
                    cnt_q <= '0;
                    if (r_q[0] <= 16'sd0) begin
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        ord_q   <= 4'd1;
                        state_q <= DOT;
                    end
                end
                DOT: begin
                    if (cnt_q == 5'd0) acc_q <= 40'(r_q[ord_q]) <<< 12;
                    else               acc_q <= acc_q - 40'(dot_prod);
                    if (cnt_q == 5'(ord_q - 4'd1)) begin
                        cnt_q   <= '0;
                        state_q <= DIV;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                DIV: begin
                    if (cnt_q == 5'd0) begin
                        if (div_abort) begin
                            err_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            // |quotient| < 2^15 is guaranteed once the abort test passes
                            rem_q <= {5'd0, acc_mag, 3'd0};
                            dsr_q <= {2'd0, e_q, 14'd0};
                            quo_q <= '0;
                            neg_q <= acc_q[39];
                            cnt_q <= 5'd1;
                        end
                    end else if (cnt_q == 5'd16) begin
                        k_q     <= neg_q ? -quo_s : quo_s;
                        cnt_q   <= 5'd1;
                        state_q <= UPD;
                    end else begin
                        if (rem_q >= dsr_q) begin
                            rem_q <= rem_q - dsr_q;
                            quo_q <= {quo_q[13:0], 1'b1};
                        end else begin
                            quo_q <= {quo_q[13:0], 1'b0};
                        end
                        dsr_q <= dsr_q >> 1;
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                UPD: begin
                    if (cnt_q < 5'(ord_q)) begin
                        b_q[j_idx] <= sat16(b_d);
                        cnt_q      <= cnt_q + 5'd1;
                    end else begin
                        for (int j = 1; j <= 9; j++)
                            if (j < int'(ord_q)) a_q[j] <= b_q[j];
                        a_q[ord_q] <= k_q >>> 3;
                        cnt_q      <= '0;
                        state_q    <= ENERG;
                    end
                end
                ENERG: begin
                    if (cnt_q == 5'd0) begin
                        t_q   <= kk_prod >>> 15;
                        cnt_q <= 5'd1;
                    end else begin
                        e_q   <= (e_d < 64'sd1) ? 32'sd1 : e_d[31:0];
                        cnt_q <= '0;
                        if (ord_q == 4'd10) begin
                            state_q <= DONE;
                        end else begin
                            ord_q   <= ord_q + 4'd1;
                            state_q <= DOT;
                        end
                    end
                end
                DONE: begin
                    for (int j = 1; j <= 10; j++) ao_q[j] <= a_q[j];
                    eo_q    <= e_q;
                    erro_q  <= err_q;
                    vout_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a1   = ao_q[1];
    assign a2   = ao_q[2];
    assign a3   = ao_q[3];
    assign a4   = ao_q[4];
    assign a5   = ao_q[5];
    assign a6   = ao_q[6];
    assign a7   = ao_q[7];
    assign a8   = ao_q[8];
    assign a9   = ao_q[9];
    assign a10  = ao_q[10];
    assign E    = eo_q;
    assign busy = busy_q;
    assign err  = erro_q;
    assign vout = vout_q;
endmodule

// File: tb/tb_lpc_levinson.sv
// Directed and reference-model bench for lpc_levinson.
module tb_lpc_levinson;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic vin = 1'b0;
    logic signed [15:0] rr [0:10];
    logic signed [15:0] a1, a2, a3, a4, a5, a6, a7, a8, a9, a10;
    logic signed [31:0] E;
    logic busy, err, vout;
    logic signed [15:0] aout [1:10];
    logic signed [15:0] m_a [1:10];
    logic signed [31:0] m_e;
    logic               m_err;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign aout[1] = a1; assign aout[2] = a2; assign aout[3] = a3; assign aout[4]  = a4;
    assign aout[5] = a5; assign aout[6] = a6; assign aout[7] = a7; assign aout[8]  = a8;
    assign aout[9] = a9; assign aout[10] = a10;

    lpc_levinson dut (
        .clk(clk), .rst(rst),
        .R0(rr[0]), .R1(rr[1]), .R2(rr[2]), .R3(rr[3]), .R4(rr[4]), .R5(rr[5]),
        .R6(rr[6]), .R7(rr[7]), .R8(rr[8]), .R9(rr[9]), .R10(rr[10]),
        .vin(vin),
        .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
        .a9(a9), .a10(a10),
        .E(E), .busy(busy), .err(err), .vout(vout)
    );

    task automatic set_geo(input bit alt);
        for (int k = 0; k <= 10; k++)
            rr[k] = (alt && (k % 2 == 1)) ? -16'(16384 >>> k) : 16'(16384 >>> k);
    endtask

    task automatic set_flat(input int r0, input int r1);
        for (int k = 0; k <= 10; k++) rr[k] = '0;
        rr[0] = 16'(r0);
        rr[1] = 16'(r1);
    endtask

    // Pulse vin, then count edges after the capture edge until vout is seen.
    task automatic run_solve(output int lat, output logic busy_cap);
        @(negedge clk); vin = 1'b1;
        @(posedge clk);
        @(negedge clk); vin = 1'b0;
        busy_cap = busy;
        lat = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (vout) begin lat = c; break; end
        end
    endtask

    task automatic ref_model();
        longint acc, e, k, t, sh, x;
        longint a [1:10];
        longint b [1:10];
        for (int j = 1; j <= 10; j++) begin a[j] = 0; b[j] = 0; end
        m_err = 1'b0;
        e = longint'(rr[0]);
        if (rr[0] <= 0) m_err = 1'b1;
        for (int i = 1; i <= 10 && !m_err; i++) begin
            acc = longint'(rr[i]) * 4096;
            for (int j = 1; j < i; j++) acc -= a[j] * longint'(rr[i-j]);
            sh = acc >>> 12;
            if (((sh < 0) ? -sh : sh) >= e) begin
                m_err = 1'b1;
            end else begin
                k = (acc * 8) / e;
                for (int j = 1; j < i; j++) begin
                    x = a[j] - ((k * a[i-j]) >>> 15);
                    if (x > 32767) x = 32767;
                    else if (x < -32768) x = -32768;
                    b[j] = x;
                end
                for (int j = 1; j < i; j++) a[j] = b[j];
                a[i] = k >>> 3;
                t = (k * k) >>> 15;
                e = e - ((t * e) >>> 15);
                if (e < 1) e = 1;
            end
        end
        for (int j = 1; j <= 10; j++) m_a[j] = a[j][15:0];
        m_e = e[31:0];
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL reset_vout: got %b expected 0", vout); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (E !== 32'sd0) begin errors++; $display("FAIL reset_E: got %0d expected 0", E); end
        for (int j = 1; j <= 10; j++) begin
            checks++;
            if (aout[j] !== 16'sd0) begin errors++; $display("FAIL reset_a%0d: got %0d expected 0", j, aout[j]); end
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_zero_lags();
        int lat; logic bc;
        set_flat(1000, 0);
        run_solve(lat, bc);
        checks++; if (bc !== 1'b1) begin errors++; $display("FAIL zero_busy_rise: got %b expected 1", bc); end
        checks++; if (lat != 302) begin errors++; $display("FAIL zero_latency: got %0d expected 302", lat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_fall: got %b expected 0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b expected 0", err); end
        checks++; if (E !== 32'sd1000) begin errors++; $display("FAIL zero_E: got %0d expected 1000", E); end
        for (int j = 1; j <= 10; j++) begin
            checks++;
            if (aout[j] !== 16'sd0) begin errors++; $display("FAIL zero_a%0d: got %0d expected 0", j, aout[j]); end
        end
        @(negedge clk);
        checks++; if (vout !== 1'b0) begin errors++; $display("FAIL zero_vout_single: got %b expected 0", vout); end
    endtask

    // Geometric lags with ratio +-1/2: exact first-order predictor a1=+-0.5, E=0.75*R0.
    task automatic test_geometric(input bit alt);
        int lat; logic bc;
        logic signed [15:0] exp_a1;
        exp_a1 = alt ? -16'sd2048 : 16'sd2048;
        set_geo(alt);
        run_solve(lat, bc);
        checks++; if (lat != 302) begin errors++; $display("FAIL geo%0d_latency: got %0d expected 302", alt, lat); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL geo%0d_err: got %b expected 0", alt, err); end
        checks++; if (a1 !== exp_a1) begin errors++; $display("FAIL geo%0d_a1: got %0d expected %0d", alt, a1, exp_a1); end
        for (int j = 2; j <= 10; j++) begin
            checks++;
            if (aout[j] !== 16'sd0) begin errors++; $display("FAIL geo%0d_a%0d: got %0d expected 0", alt, j, aout[j]); end
        end
        checks++; if (E !== 32'sd12288) begin errors++; $display("FAIL geo%0d_E: got %0d expected 12288", alt, E); end
    endtask

    task automatic test_abort();
        int lat; logic bc;
        set_flat(0, 500);
        run_solve(lat, bc);
        checks++; if (lat != 2) begin errors++; $display("FAIL abort_r0_latency: got %0d expected 2", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_r0_err: got %b expected 1", err); end
        checks++; if (E !== 32'sd0) begin errors++; $display("FAIL abort_r0_E: got %0d expected 0", E); end
        for (int j = 1; j <= 10; j++) begin
            checks++;
            if (aout[j] !== 16'sd0) begin errors++; $display("FAIL abort_r0_a%0d: got %0d expected 0", j, aout[j]); end
        end
        set_flat(100, 100);
        run_solve(lat, bc);
        checks++; if (lat < 0) begin errors++; $display("FAIL abort_k_timeout: got no vout expected vout"); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_k_err: got %b expected 1", err); end
        checks++; if (E !== 32'sd100) begin errors++; $display("FAIL abort_k_E: got %0d expected 100", E); end
        checks++; if (a1 !== 16'sd0) begin errors++; $display("FAIL abort_k_a1: got %0d expected 0", a1); end
    endtask

    // Second vin mid-solve and a vin sampled on the done edge must both be dropped.
    task automatic test_back_to_back();
        int nv, lat;
        nv = 0; lat = -1;
        set_geo(1'b0);
        @(negedge clk); vin = 1'b1;
        @(posedge clk);
        @(negedge clk); vin = 1'b0;
        for (int c = 1; c <= 700; c++) begin
            @(negedge clk);
            if (vout) begin nv++; if (lat < 0) lat = c; end
            if (c == 50) set_geo(1'b1);
            vin = (c == 50 || c == 301);
            if (c == 303) begin
                checks++;
                if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_after_done: got %b expected 0", busy); end
            end
        end
        checks++; if (nv != 1) begin errors++; $display("FAIL b2b_vout_count: got %0d expected 1", nv); end
        checks++; if (lat != 302) begin errors++; $display("FAIL b2b_latency: got %0d expected 302", lat); end
        checks++; if (a1 !== 16'sd2048) begin errors++; $display("FAIL b2b_a1: got %0d expected 2048", a1); end
        checks++; if (E !== 32'sd12288) begin errors++; $display("FAIL b2b_E: got %0d expected 12288", E); end
    endtask

    task automatic test_reset_mid();
        int nv, lat; logic bc;
        nv = 0;
        set_geo(1'b1);
        @(negedge clk); vin = 1'b1;
        @(posedge clk);
        @(negedge clk); vin = 1'b0;
        repeat (150) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++; if (a1 !== 16'sd0) begin errors++; $display("FAIL rstmid_a1: got %0d expected 0", a1); end
        checks++; if (E !== 32'sd0) begin errors++; $display("FAIL rstmid_E: got %0d expected 0", E); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (vout) nv++;
        end
        checks++; if (nv != 0) begin errors++; $display("FAIL rstmid_stray_vout: got %0d expected 0", nv); end
        set_geo(1'b0);
        run_solve(lat, bc);
        checks++; if (lat != 302) begin errors++; $display("FAIL rstmid_latency: got %0d expected 302", lat); end
        checks++; if (a1 !== 16'sd2048) begin errors++; $display("FAIL rstmid_a1_after: got %0d expected 2048", a1); end
        checks++; if (E !== 32'sd12288) begin errors++; $display("FAIL rstmid_E_after: got %0d expected 12288", E); end
    endtask

    task automatic test_random();
        int lat, s; logic bc;
        int x [0:19];
        for (int n = 0; n < 10; n++) begin
            if (n < 8) begin
                // lags from a real signal: positive semi-definite, mostly solvable
                for (int i = 0; i < 20; i++) x[i] = int'($urandom_range(50)) - 25;
                for (int k = 0; k <= 10; k++) begin
                    s = 0;
                    for (int i = 0; i + k < 20; i++) s += x[i] * x[i+k];
                    rr[k] = 16'(s);
                end
            end else begin
                // arbitrary lags: exercises mid-order aborts
                rr[0] = 16'(int'($urandom_range(7000)) + 1000);
                for (int k = 1; k <= 10; k++) rr[k] = 16'(int'($urandom_range(6000)) - 3000);
            end
            ref_model();
            run_solve(lat, bc);
            checks++; if (lat < 0) begin errors++; $display("FAIL rnd%0d_timeout: got no vout expected vout", n); end
            checks++; if (err !== m_err) begin errors++; $display("FAIL rnd%0d_err: got %b expected %b", n, err, m_err); end
            checks++; if (E !== m_e) begin errors++; $display("FAIL rnd%0d_E: got %0d expected %0d", n, E, m_e); end
            for (int j = 1; j <= 10; j++) begin
                checks++;
                if (aout[j] !== m_a[j]) begin errors++; $display("FAIL rnd%0d_a%0d: got %0d expected %0d", n, j, aout[j], m_a[j]); end
            end
        end
    endtask

    initial begin
        for (int k = 0; k <= 10; k++) rr[k] = '0;
        test_reset();
        test_zero_lags();
        test_geometric(1'b0);
        test_geometric(1'b1);
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/lpc_levinson.md
LPC_LEVINSON -- requirements
Module: lpc_levinson

Interface
REQ-001 SHALL declare ports, clock and reset first:
- clk  in  1  rising-edge clock, single domain.
- rst  in  1  asynchronous active-low reset.
- R0..R10  in  16 each  signed autocorrelation lags, integer scale.
- vin  in  1  one-cycle strobe, R0..R10 valid.
- a1..a10  out  16 each  signed predictor coefficients, Q12.
- E  out  32  signed final prediction-error energy, integer.
- busy  out  1  high from capture until the cycle vout asserts.
- err  out  1  solve aborted.
- vout  out  1  one-cycle done strobe.

REQ-002 SHALL have no parameters; the order is fixed at 10.

Function
REQ-003 SHALL capture R0..R10 into internal registers on the first clk edge where vin=1 and busy=0; busy SHALL rise on that edge.
REQ-004 SHALL ignore vin while busy=1, with no effect on the current solve and no queued request.
REQ-005 SHALL implement FSM states IDLE, LOAD, DOT, DIV, UPD, ENERG, DONE:
- IDLE->LOAD on capture.
- LOAD->DOT with i=1.
- DOT->DIV->UPD->ENERG per order i.
- ENERG->DOT with i+1 while i<10, else ->DONE.
- DONE->IDLE.
REQ-006 LOAD SHALL:
- clear internal a[1..10];
- set E=R0 (sign-extended);
- go directly to DONE with err=1 if R0<=0.
REQ-007 DOT SHALL take i cycles: acc = (R[i]<<12) - sum over j=1..i-1 of a[j]*R[i-j], 40-bit signed, one multiply-accumulate per cycle.
REQ-008 DIV SHALL take 17 cycles:
- k = (acc<<3)/E, Q15, truncated toward zero, via a sequential restoring divider.
- If |acc>>12| >= E, SHALL abort to DONE with err=1.
REQ-009 UPD SHALL take i cycles:
- for j=1..i-1: b[j] = a[j] - ((k*a[i-j])>>>15);
- final cycle: a[j]=b[j] for j<i and a[i]=k>>>3.
- All results SHALL saturate to [-32768,32767].
REQ-010 ENERG SHALL take 2 cycles: E = E - ((((k*k)>>>15)*E)>>>15), 32-bit, floored at 1.
REQ-011 Latency on a successful solve SHALL be exactly 302 cycles:
- 1 for LOAD;
- sum over i=1..10 of (2i+19) = 300;
- 1 for DONE.
- vout SHALL be high on the 302nd edge after the capture edge.
REQ-012 In DONE, SHALL load outputs a1..a10, E and err in the same edge vout rises. Outputs SHALL hold until the next DONE; busy SHALL fall on that edge.
REQ-013 On abort, SHALL output the coefficients complete through order i-1, with a[i..10]=0 and E equal to the last valid energy. Abort from LOAD SHALL give vout 2 cycles after capture.
REQ-014 vout SHALL never be high for two consecutive cycles.
REQ-015 vin arriving in the same cycle that vout asserts SHALL be ignored, because busy is still 1 in that cycle.

Reset
REQ-016 rst=0 SHALL asynchronously force:
- state=IDLE;
- busy=0, vout=0, err=0;
- a1..a10=0, E=0;
- all internal registers to 0.
REQ-017 Deassertion of rst SHALL take effect at the next clk edge. Reset mid-solve SHALL discard the solve with no vout.

Verification
REQ-018 SHALL cover: R0=1000, R1..R10=0 -> a1..a10=0, E=1000, err=0, vout exactly 302 cycles after capture.
REQ-019 SHALL cover: R0=16384, R1=8192, R2=4096, R3=2048, ... halving each lag -> a1 within 2048±2, a2..a10 within ±2, err=0.
REQ-020 SHALL cover: R0=0 -> vout 2 cycles after capture, err=1, a all 0, E=0. R0=100, R1=100 -> err=1, a all 0, E=100.
REQ-021 SHALL cover: vin pulsed again 50 cycles after capture with different data -> result matches the first data set, only one vout.
REQ-022 SHALL cover: rst low at cycle 150 of a solve -> all outputs 0 immediately, no vout; a new vin after release -> correct 302-cycle result.
REQ-023 SHALL cover: random valid autocorrelation sets compared against a bit-accurate reference model -> exact match of a1..a10, E and err.
